// File: rtl/muldiv_seq.sv
// muldiv_seq: RV32M multiply/divide sequencer that borrows the core ALU for each shift-add/sub step.
// Optional feature: define MULDIV_SIGNED_EN to support MULH, MULHSU, DIV and REM.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctr,
  input  logic [XLEN-1:0] alu_out,
  output logic [2:0]      state_dbg
);
  // Handshake: a request is taken on a rising edge with start & ready (ready only in IDLE);
  // done is a one-cycle pulse with result valid, and result holds until the next completion.
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  state_t          state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] hi, lo, mc;
  logic [XLEN-1:0] hi_nx, lo_nx, mc_nx, res_nx;
  logic [2:0]      op_q, op_nx;
  logic            neg, neg_nx;
  logic            signed_op, neg_in, carry, ge;
  logic [XLEN-1:0] a_mag, b_mag, div_a;

  assign signed_op = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg;
  assign a_neg  = signed_op && a[XLEN-1];
  assign b_neg  = ((op == 3'd1) || (op == 3'd4) || (op == 3'd6)) && b[XLEN-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign neg_in = (op == 3'd6) ? a_neg : (a_neg ^ b_neg);
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign neg_in = 1'b0;
`endif

  // hi/lo/mc double as rem/quo/dv during division.
  assign div_a = {hi[XLEN-2:0], lo[XLEN-1]};

  always_comb begin
    state_nx = state;
    hi_nx    = hi;
    lo_nx    = lo;
    mc_nx    = mc;
    op_nx    = op_q;
    neg_nx   = neg;
    res_nx   = result;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctr  = 4'd0;
    carry    = 1'b0;
    ge       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          op_nx  = op;
          neg_nx = neg_in;
          hi_nx  = '0;
          lo_nx  = a_mag;
          mc_nx  = b_mag;
          if (signed_op && !SIGNED_EN) begin
            state_nx = DONE;
            res_nx   = '0;
          end else if (op[2] && (b == '0)) begin
            state_nx = DONE;
            res_nx   = op[1] ? a : '1;
          end else begin
            state_nx = op[2] ? DIV : MUL;
          end
        end
      end
      MUL: begin
        alu_a = hi;
        alu_b = lo[0] ? mc : '0;
        carry = (alu_out < hi);
        hi_nx = {carry, alu_out[XLEN-1:1]};
        lo_nx = {alu_out[0], lo[XLEN-1:1]};
      end
      DIV: begin
        alu_a   = div_a;
        alu_b   = mc;
        alu_ctr = 4'd1;
        ge      = hi[XLEN-1] | (div_a >= mc);
        hi_nx   = ge ? alu_out : div_a;
        lo_nx   = {lo[XLEN-2:0], ge};
      end
      FIX: begin
        // High-word negation of a 64-bit product borrows from the low word.
        alu_b    = (op_q == 3'd4) ? lo : hi;
        alu_ctr  = 4'd1;
        res_nx   = op_q[2] ? alu_out : alu_out - {{(XLEN-1){1'b0}}, (lo != '0)};
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (((state == MUL) || (state == DIV)) && (cnt == '1)) begin
      if (neg) begin
        state_nx = FIX;
      end else begin
        state_nx = DONE;
        res_nx   = ((op_q == 3'd0) || (op_q == 3'd4) || (op_q == 3'd5)) ? lo_nx : hi_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      mc     <= '0;
      op_q   <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= ((state == MUL) || (state == DIV)) ? cnt + {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      hi     <= hi_nx;
      lo     <= lo_nx;
      mc     <= mc_nx;
      op_q   <= op_nx;
      neg    <= neg_nx;
      result <= res_nx;
    end
  end

  assign ready     = (state == IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed stimulus for muldiv_seq, checked by a scoreboard
// against an arithmetic reference model; honours MULDIV_SIGNED_EN like the design.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        ready, done;
  logic [31:0] result, alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctr;
  logic [2:0]  state_dbg;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_done_cyc = -100;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  logic [31:0] held = '0;
  logic [2:0]  cur_op = '0;
  logic        cur_bz = 1'b0;
  bit          prev_hold = 1'b0;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU model: 0 = add, 1 = subtract.
  assign alu_out = (alu_ctr == 4'd1) ? alu_a - alu_b : alu_a + alu_b;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_out(alu_out),
    .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_signed_op(input logic [2:0] f);
    return (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    longint      ux = longint'({32'b0, x});
    longint      uy = longint'({32'b0, y});
    logic [63:0] p;
    if (is_signed_op(f) && !SIGNED_EN) return 32'h0;
    case (f)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFFFFFF : 32'(sx / sy);
      3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: return (y == 0) ? x : 32'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Cycles from the accepting edge to the cycle in which done is high (inclusive).
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (is_signed_op(f) && !SIGNED_EN) return 1;
    if (f[2] && (y == 0)) return 1;
    case (f)
      3'd1, 3'd4: return 33 + int'(x[31] ^ y[31]);
      3'd2, 3'd6: return 33 + int'(x[31]);
      default:    return 33;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input bit hold);
    int waited = 0;
    @(negedge clk);
    while (!ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      n_checks++;
      $display("FAIL ready_timeout: ready still 0 after %0d cycles, expected 1", waited);
      start = 1'b0;
      return;
    end
    start = 1'b1; op = f; a = x; b = y;
    @(posedge clk);
    #1;
    exp_q.push_back(ref_result(f, x, y));
    lat_q.push_back(ref_latency(f, x, y));
    acc_q.push_back(cyc);
    // With start held, the next accept closes the IDLE cycle right after the done cycle.
    if (prev_hold) check("b2b_accept", cyc, last_done_cyc + 2);
    cur_op = f;
    cur_bz = (y == 0);
    prev_hold = hold;
    if (hold) begin
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    end else begin
      start = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      held = '0;
    end else begin
      if (ready || done) check("alu_idle", {alu_ctr, alu_a | alu_b}, 64'h0);
      else if (!cur_bz && (cur_op == 3'd5 || cur_op == 3'd7)) check("alu_ctr_div", alu_ctr, 64'd1);
      else if (cur_op == 3'd0 || cur_op == 3'd3) check("alu_ctr_mul", alu_ctr, 64'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: done=1 with result %h, expected no completion", result);
        end else begin
          check("result", result, exp_q.pop_front());
          check("latency", cyc - acc_q.pop_front() + 1, lat_q.pop_front());
        end
        held = result;
        last_done_cyc = cyc;
      end else begin
        check("result_hold", result, held);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0]  d_op   [13] = '{3'd3, 3'd0, 3'd5, 3'd7, 3'd5, 3'd5, 3'd7, 3'd4, 3'd6, 3'd1, 3'd4, 3'd6, 3'd2};
  logic [31:0] d_a    [13] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100, 32'hFFFFFFFF, 32'd5, 32'd5,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
  logic [31:0] d_b    [13] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd1, 32'd0, 32'd0,
                               32'd2, 32'd2, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3};
  bit          d_hold [13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", ready, 64'd1);
    check("reset_done", done, 64'd0);
    check("reset_result", result, 64'd0);
    #1 rst = 1'b0;

    for (int i = 0; i < 13; i++) issue(d_op[i], d_a[i], d_b[i], d_hold[i]);

    // Reset in the middle of a multiply discards it.
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_ready", ready, 64'd1);
    check("midreset_done", done, 64'd0);
    check("midreset_result", result, 64'd0);
    exp_q.delete(); lat_q.delete(); acc_q.delete();
    prev_hold = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

    for (int i = 0; i < 150; i++)
      issue(3'($urandom_range(0, 7)), pick(), pick(), (i != 149) && ($urandom_range(0, 2) == 0));

    start = 1'b0;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
